// File: rtl/acl_kernel_clk_ctrl_master.sv
// Avalon-MM master for the kernel clock block's ctrl slave: single-beat commands,
// credit-bounded pipelined reads, and a timeout drain that synthesizes error responses.
module acl_kernel_clk_ctrl_master #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset_n,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [ADDR_W-1:0]                   cmd_address,
    input  logic [DATA_W-1:0]                   cmd_writedata,
    input  logic [DATA_W/8-1:0]                 cmd_byteenable,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [DATA_W-1:0]                   rsp_readdata,
    output logic                                rsp_error,
    output logic [ADDR_W-1:0]                   ctrl_address,
    output logic [DATA_W-1:0]                   ctrl_writedata,
    output logic [DATA_W/8-1:0]                 ctrl_byteenable,
    output logic                                ctrl_write,
    output logic                                ctrl_read,
    output logic                                ctrl_burstcount,
    output logic                                ctrl_debugaccess,
    input  logic                                ctrl_waitrequest,
    input  logic [DATA_W-1:0]                   ctrl_readdata,
    input  logic                                ctrl_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]        pending_count,
    output logic                                timeout_err,
    input  logic                                err_clear
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PCW   = $clog2(MAX_PENDING) + 1;
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]    TO_LAST   = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [PCW:0]     CREDIT    = (PCW + 1)'(MAX_PENDING);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_PENDING - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   ctrl_address_q, ctrl_address_d;
    logic [DATA_W-1:0]   ctrl_writedata_q, ctrl_writedata_d;
    logic [BE_W-1:0]     ctrl_byteenable_q, ctrl_byteenable_d;
    logic                ctrl_write_q, ctrl_write_d;
    logic                ctrl_read_q, ctrl_read_d;
    logic                hold_write_q, hold_write_d;
    logic [PCW-1:0]      pending_q, pending_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;

    // Each FIFO entry is {error, data}.
    logic [DATA_W:0]     fifo_mem_q [MAX_PENDING];
    logic [DATA_W:0]     fifo_mem_d [MAX_PENDING];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PCW-1:0]      fifo_count_q, fifo_count_d;

    logic                acc_read;
    logic                rdv_live;
    logic                rdv_drop;
    logic                drain_step;
    logic                push;
    logic                pop;
    logic                fire;
    logic                credit_ok;
    logic [PCW:0]        credit_sum;
    logic [DATA_W:0]     push_entry;
    logic [DATA_W:0]     head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        acc_read   = ctrl_read_q && !ctrl_waitrequest;
        rdv_live   = ctrl_readdatavalid && (state_q != S_DRAIN) && (pending_q != '0);
        rdv_drop   = ctrl_readdatavalid && !rdv_live;
        drain_step = (state_q == S_DRAIN) && (pending_q != '0);
        push       = rdv_live || drain_step;
        push_entry = drain_step ? {1'b1, {DATA_W{1'b0}}} : {1'b0, ctrl_readdata};
        pop        = rsp_valid && rsp_ready;
        // Credit counts both in-flight reads and buffered responses, so the FIFO cannot overflow.
        credit_sum = {1'b0, pending_q} + {1'b0, fifo_count_q};
        credit_ok  = credit_sum < CREDIT;
        // A return in the same cycle clears the counter, so it beats the timeout.
        fire       = (TIMEOUT > 0) && (state_q != S_DRAIN) && (pending_q != '0) &&
                     !ctrl_readdatavalid && (cnt_q == TO_LAST);
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((TIMEOUT == 0) || (state_q == S_DRAIN) || (pending_q == '0) ||
            ctrl_readdatavalid || fire) begin
            cnt_d = '0;
        end

        timeout_err_d = timeout_err_q;
        if (err_clear) timeout_err_d = 1'b0;
        if (fire || rdv_drop) timeout_err_d = 1'b1;

        pending_d = pending_q;
        if (acc_read && !(rdv_live || drain_step)) begin
            pending_d = pending_q + 1'b1;
        end else if (!acc_read && (rdv_live || drain_step)) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d             = ptr_next(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
        if (push && !pop) fifo_count_d = fifo_count_q + 1'b1;
        else if (!push && pop) fifo_count_d = fifo_count_q - 1'b1;
    end

    always_comb begin
        state_d           = state_q;
        ctrl_address_d    = ctrl_address_q;
        ctrl_writedata_d  = ctrl_writedata_q;
        ctrl_byteenable_d = ctrl_byteenable_q;
        ctrl_write_d      = ctrl_write_q;
        ctrl_read_d       = ctrl_read_q;
        hold_write_d      = hold_write_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ctrl_address_d    = cmd_address;
                    ctrl_writedata_d  = cmd_writedata;
                    ctrl_byteenable_d = cmd_byteenable;
                    hold_write_d      = cmd_write;
                    ctrl_write_d      = cmd_write;
                    ctrl_read_d       = !cmd_write && credit_ok;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((ctrl_read_q || ctrl_write_q) && !ctrl_waitrequest) begin
                    ctrl_write_d = 1'b0;
                    ctrl_read_d  = 1'b0;
                    state_d      = S_IDLE;
                end else if (!hold_write_q && !ctrl_read_q) begin
                    ctrl_read_d = credit_ok;
                end
            end
            S_DRAIN: begin
                if (pending_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout recovery abandons any command still held in the issue register.
        if (fire) begin
            state_d      = S_DRAIN;
            ctrl_write_d = 1'b0;
            ctrl_read_d  = 1'b0;
        end

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q           <= S_IDLE;
            cmd_ready_q       <= 1'b0;
            ctrl_address_q    <= '0;
            ctrl_writedata_q  <= '0;
            ctrl_byteenable_q <= '0;
            ctrl_write_q      <= 1'b0;
            ctrl_read_q       <= 1'b0;
            hold_write_q      <= 1'b0;
            pending_q         <= '0;
            cnt_q             <= '0;
            timeout_err_q     <= 1'b0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            fifo_count_q      <= '0;
            for (int i = 0; i < MAX_PENDING; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q           <= state_d;
            cmd_ready_q       <= cmd_ready_d;
            ctrl_address_q    <= ctrl_address_d;
            ctrl_writedata_q  <= ctrl_writedata_d;
            ctrl_byteenable_q <= ctrl_byteenable_d;
            ctrl_write_q      <= ctrl_write_d;
            ctrl_read_q       <= ctrl_read_d;
            hold_write_q      <= hold_write_d;
            pending_q         <= pending_d;
            cnt_q             <= cnt_d;
            timeout_err_q     <= timeout_err_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            fifo_count_q      <= fifo_count_d;
            fifo_mem_q        <= fifo_mem_d;
        end
    end

    assign head             = fifo_mem_q[rd_ptr_q];
    assign rsp_valid        = (fifo_count_q != '0);
    assign rsp_error        = rsp_valid && head[DATA_W];
    assign rsp_readdata     = (rsp_valid && !head[DATA_W]) ? head[DATA_W-1:0] : '0;
    assign cmd_ready        = cmd_ready_q;
    assign ctrl_address     = ctrl_address_q;
    assign ctrl_writedata   = ctrl_writedata_q;
    assign ctrl_byteenable  = ctrl_byteenable_q;
    assign ctrl_write       = ctrl_write_q;
    assign ctrl_read        = ctrl_read_q;
    assign ctrl_burstcount  = 1'b1;
    assign ctrl_debugaccess = 1'b0;
    assign pending_count    = pending_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: doc/acl_kernel_clk_ctrl_master.md
# acl_kernel_clk_ctrl_master

Avalon-MM master that drives the kernel clock block's `ctrl` slave port (PLL reconfiguration and counter registers) from a simple command/response stream. It sits between the host-side control logic and the kernel clock generator. It converts single commands into single-beat Avalon transactions and honours `waitrequest`. It supports pipelined reads with `readdatavalid`, bounds outstanding reads, and recovers from a hung slave with a timeout drain.

## Interface
- `ADDR_W`, 11: Avalon word address width.
- `DATA_W`, 32: data width. Byteenable width is `DATA_W/8`.
- `MAX_PENDING`, 4: maximum outstanding reads. Must be a power of 2, 1..16. Also the response FIFO depth.
- `TIMEOUT`, 1023: cycles without `readdatavalid` while reads are pending before drain. 0 disables the timeout.
- `clk_clk` in 1: sole clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake. Transfer occurs when both are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_address` in ADDR_W, `cmd_writedata` in DATA_W, `cmd_byteenable` in DATA_W/8: command payload.
- `rsp_valid` out 1 / `rsp_ready` in 1: read-response handshake.
- `rsp_readdata` out DATA_W: read data. Forced to 0 when `rsp_error` = 1.
- `rsp_error` out 1: response was synthesized by a timeout drain.
- `ctrl_address` out ADDR_W, `ctrl_writedata` out DATA_W, `ctrl_byteenable` out DATA_W/8, `ctrl_write` out 1, `ctrl_read` out 1: Avalon master request.
- `ctrl_burstcount` out 1: constant 1.
- `ctrl_debugaccess` out 1: constant 0.
- `ctrl_waitrequest` in 1, `ctrl_readdata` in DATA_W, `ctrl_readdatavalid` in 1: Avalon slave responses.
- `pending_count` out clog2(MAX_PENDING)+1: reads issued but not yet returned.
- `timeout_err` out 1: sticky flag. Cleared only by `err_clear`.
- `err_clear` in 1: synchronous clear of `timeout_err`.

## Operation
- State machine: IDLE (hold register empty), ISSUE (hold register full), DRAIN (timeout recovery).
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, capture the payload into the hold register and go to ISSUE.
- ISSUE:
  - `cmd_ready` = 0.
  - Write: assert `ctrl_write` immediately.
  - Read: assert `ctrl_read` only when `pending_count + fifo_count < MAX_PENDING` (credit). Credit can only grow while waiting, so a request, once asserted, stays asserted.
  - Request and payload are held stable while `ctrl_waitrequest` = 1.
  - Request accepted (asserted with `waitrequest` = 0): drop the request next cycle, return to IDLE, and increment `pending_count` if it was a read.
- Reads:
  - Each `ctrl_readdatavalid` pushes {data, error=0} into the FIFO and decrements `pending_count`.
  - If accept and return happen in the same cycle, `pending_count` is unchanged.
  - The FIFO can never overflow, by credit construction.
- Writes produce no response.
- Timeout:
  - The counter clears whenever `pending_count` = 0 or `ctrl_readdatavalid` = 1. Otherwise it increments.
  - When the counter reaches TIMEOUT: set `timeout_err`, go to DRAIN, and latch N = `pending_count`.
  - If `readdatavalid` arrives in the same cycle as the counter reaching TIMEOUT, `readdatavalid` wins: no timeout.
- DRAIN:
  - `cmd_ready` = 0 and no requests are issued.
  - Push one {0, error=1} response per cycle, N times, decrementing `pending_count` each time.
  - At 0, go to IDLE.
  - `ctrl_readdatavalid` while in DRAIN, or while `pending_count` = 0: the data is dropped and `timeout_err` is set.
- `err_clear` and a `timeout_err` set in the same cycle: the set wins.

## Timing
- Every `ctrl_*` output is registered.
- A command accepted in cycle N appears on `ctrl_*` in cycle N+1.
- Peak throughput with zero `waitrequest`: one command every 2 cycles.
- `ctrl_readdatavalid` in cycle M gives `rsp_valid` in cycle M+1 if the FIFO was empty. Otherwise responses leave in order.
- FIFO output is first-word fall-through. The pop occurs on `rsp_valid && rsp_ready`.
- Reset values:
  - `cmd_ready` = 0 during reset, 1 from the first cycle after release.
  - All other outputs 0, except `ctrl_burstcount` = 1.
- Reset mid-transaction: `ctrl_read`/`ctrl_write` drop asynchronously; pending reads, the FIFO, the counter and the flags are all cleared.

## Test plan
- Single write, `waitrequest` low: cmd(write, addr 0x010, data 0x12345678, be 0xF) -> `ctrl_write` = 1 for exactly 1 cycle, one cycle after the handshake, with matching payload; no response.
- Read with `waitrequest` high for 3 cycles: `ctrl_read` and `ctrl_address` are held stable 4 cycles. `readdatavalid` 2 cycles later with 0xCAFE0001 -> `rsp_valid` next cycle, data 0xCAFE0001, `rsp_error` 0.
- Credit limit: 6 back-to-back reads with a silent slave and `rsp_ready` = 0 -> exactly 4 reads accepted, `pending_count` = 4, the 5th read held in ISSUE with `ctrl_read` = 0. After 4 returns and 1 pop, the 5th read issues.
- Timeout with TIMEOUT = 8:
  - 2 reads, no return -> after 8 idle cycles `timeout_err` = 1 and 2 responses with `rsp_error` = 1 and data 0.
  - A late `readdatavalid` is dropped.
  - `err_clear` clears the flag.
- Reset asserted while `ctrl_read` is held under `waitrequest` -> `ctrl_read` = 0 immediately; after release `pending_count` = 0 and `rsp_valid` = 0.
